// File: rtl/mem_arbiter.sv
// ---------------------------------------------------------------------------
// mem_arbiter
//
// Shares one single-ported unified memory between the fetch stage
// (instruction reads) and the memory stage (data loads/stores).
// Data accesses win arbitration unless fetch has been passed over
// STARVE_LIMIT times in a row. A watchdog aborts any grant that sees no
// m_ack within TIMEOUT cycles; the aborted requester still gets its ready
// pulse, with zero data and err set.
//
// Handshakes:
//   requester side: *_req is raised and held until the matching *_ready
//     one-cycle pulse; *_rdata is valid only in the ready cycle.
//   memory side: m_req with stable m_we/m_addr/m_wdata/m_be is held until
//     a one-cycle m_ack; m_rdata is sampled with m_ack.
//
// Ports:
//   clk, rst                      clock, asynchronous active-high reset
//   if_req, if_addr               fetch request / byte address
//   if_rdata, if_ready            fetch response data / completion pulse
//   d_req, d_we, d_addr,
//   d_wdata, d_be                 data request, store flag, address, data, byte enables
//   d_rdata, d_ready              data response / completion pulse
//   m_req, m_we, m_addr,
//   m_wdata, m_be                 memory request bus
//   m_rdata, m_ack                memory response
//   err                           abort indication, only with a ready pulse
// ---------------------------------------------------------------------------
module mem_arbiter #(
    parameter int DATA_WIDTH   = 32,
    parameter int STARVE_LIMIT = 4,
    parameter int TIMEOUT      = 64
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  if_req,
    input  logic [DATA_WIDTH-1:0] if_addr,
    output logic [DATA_WIDTH-1:0] if_rdata,
    output logic                  if_ready,
    input  logic                  d_req,
    input  logic                  d_we,
    input  logic [DATA_WIDTH-1:0] d_addr,
    input  logic [DATA_WIDTH-1:0] d_wdata,
    input  logic [3:0]            d_be,
    output logic [DATA_WIDTH-1:0] d_rdata,
    output logic                  d_ready,
    output logic                  m_req,
    output logic                  m_we,
    output logic [DATA_WIDTH-1:0] m_addr,
    output logic [DATA_WIDTH-1:0] m_wdata,
    output logic [3:0]            m_be,
    input  logic [DATA_WIDTH-1:0] m_rdata,
    input  logic                  m_ack,
    output logic                  err
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GNT_I = 2'd1,
        GNT_D = 2'd2,
        RESP  = 2'd3
    } state_t;

    localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);
    localparam logic [7:0] WD_LAST    = 8'(TIMEOUT - 1);

    state_t                state_q, state_d;
    logic [3:0]            starve_cnt_q, starve_cnt_d;
    logic [7:0]            wd_cnt_q, wd_cnt_d;
    logic                  abort_q, abort_d;
    // Remembers which requester owns the current transaction so RESP
    // can steer the ready pulse after the GNT_x state is gone.
    logic                  gnt_data_q, gnt_data_d;
    logic                  we_q, we_d;
    logic [DATA_WIDTH-1:0] addr_q, addr_d;
    logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
    logic [3:0]            be_q, be_d;
    logic [DATA_WIDTH-1:0] if_rdata_q, if_rdata_d;
    logic [DATA_WIDTH-1:0] d_rdata_q, d_rdata_d;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q      <= IDLE;
            starve_cnt_q <= '0;
            wd_cnt_q     <= '0;
            abort_q      <= 1'b0;
            gnt_data_q   <= 1'b0;
            we_q         <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            be_q         <= '0;
            if_rdata_q   <= '0;
            d_rdata_q    <= '0;
        end else begin
            state_q      <= state_d;
            starve_cnt_q <= starve_cnt_d;
            wd_cnt_q     <= wd_cnt_d;
            abort_q      <= abort_d;
            gnt_data_q   <= gnt_data_d;
            we_q         <= we_d;
            addr_q       <= addr_d;
            wdata_q      <= wdata_d;
            be_q         <= be_d;
            if_rdata_q   <= if_rdata_d;
            d_rdata_q    <= d_rdata_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        starve_cnt_d = starve_cnt_q;
        wd_cnt_d     = wd_cnt_q;
        abort_d      = abort_q;
        gnt_data_d   = gnt_data_q;
        we_d         = we_q;
        addr_d       = addr_q;
        wdata_d      = wdata_q;
        be_d         = be_q;
        if_rdata_d   = if_rdata_q;
        d_rdata_d    = d_rdata_q;

        unique case (state_q)
            IDLE: begin
                // Data wins unless fetch is also waiting and has already
                // been passed over STARVE_LIMIT times.
                if (d_req && !(if_req && (starve_cnt_q == STARVE_MAX))) begin
                    state_d    = GNT_D;
                    gnt_data_d = 1'b1;
                    we_d       = d_we;
                    addr_d     = d_addr;
                    wdata_d    = d_wdata;
                    be_d       = d_be;
                    if (!if_req) begin
                        starve_cnt_d = '0;
                    end else if (starve_cnt_q != STARVE_MAX) begin
                        starve_cnt_d = starve_cnt_q + 4'd1;
                    end
                end else if (if_req) begin
                    state_d      = GNT_I;
                    gnt_data_d   = 1'b0;
                    we_d         = 1'b0;
                    addr_d       = if_addr;
                    wdata_d      = '0;
                    be_d         = 4'hF;
                    starve_cnt_d = '0;
                end
            end
            GNT_I, GNT_D: begin
                // An ack in the timeout cycle takes precedence over the abort.
                if (m_ack) begin
                    state_d = RESP;
                    if (gnt_data_q) d_rdata_d  = m_rdata;
                    else            if_rdata_d = m_rdata;
                end else if (wd_cnt_q == WD_LAST) begin
                    state_d = RESP;
                    abort_d = 1'b1;
                    if (gnt_data_q) d_rdata_d  = '0;
                    else            if_rdata_d = '0;
                end else begin
                    wd_cnt_d = wd_cnt_q + 8'd1;
                end
            end
            RESP: begin
                state_d  = IDLE;
                wd_cnt_d = '0;
                abort_d  = 1'b0;
            end
            default: state_d = IDLE;
        endcase
    end

    // Everything below decodes registered state only, so an asynchronous
    // reset forces m_req and both ready pulses low immediately.
    assign m_req    = (state_q == GNT_I) || (state_q == GNT_D);
    assign m_we     = we_q;
    assign m_addr   = addr_q;
    assign m_wdata  = wdata_q;
    assign m_be     = be_q;
    assign if_ready = (state_q == RESP) && !gnt_data_q;
    assign d_ready  = (state_q == RESP) && gnt_data_q;
    assign err      = (state_q == RESP) && abort_q;
    assign if_rdata = if_rdata_q;
    assign d_rdata  = d_rdata_q;

endmodule
